// File: rtl/vga_timing.sv
// VGA raster timing generator: registered position, sync, visible and frame counter.
// Define VGA_TIMING_CE_EN to advance only on pix_ce; otherwise the raster advances every clk.
module vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int COORD_W   = 10,
    parameter int FRAME_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_ce,
    output logic               visible,
    output logic               hsync,
    output logic               vsync,
    output logic [COORD_W-1:0] column,
    output logic [COORD_W-1:0] row,
    output logic               new_line,
    output logic               new_frame,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic HS_ACT = (HSYNC_POL != 0);
    localparam logic VS_ACT = (VSYNC_POL != 0);

    logic               adv;
    logic               started;
    logic               load;
    logic [COORD_W-1:0] col_n;
    logic [COORD_W-1:0] row_n;
    logic [FRAME_W-1:0] fc_n;

`ifdef VGA_TIMING_CE_EN
    assign adv = pix_ce;
`else
    logic unused_pix_ce;
    assign unused_pix_ce = pix_ce;
    assign adv = 1'b1;
`endif

    // The first edge out of reset presents pixel (0,0) instead of advancing past it.
    always_comb begin
        col_n = column;
        row_n = row;
        fc_n  = frame_count;
        load  = 1'b0;
        if (!started) begin
            col_n = '0;
            row_n = '0;
            load  = 1'b1;
        end else if (adv) begin
            load = 1'b1;
            if (column == H_LAST) begin
                col_n = '0;
                if (row == V_LAST) begin
                    row_n = '0;
                    fc_n  = frame_count + 1'b1;
                end else begin
                    row_n = row + 1'b1;
                end
            end else begin
                col_n = column + 1'b1;
            end
        end
    end

    // Flags are decoded from the next position so they line up with column/row.
    always_ff @(posedge clk) begin
        if (reset) begin
            started     <= 1'b0;
            column      <= '0;
            row         <= '0;
            frame_count <= '0;
            visible     <= 1'b0;
            hsync       <= ~HS_ACT;
            vsync       <= ~VS_ACT;
            new_line    <= 1'b0;
            new_frame   <= 1'b0;
        end else if (load) begin
            started     <= 1'b1;
            column      <= col_n;
            row         <= row_n;
            frame_count <= fc_n;
            visible     <= (col_n < H_VIS) && (row_n < V_VIS);
            hsync       <= ((col_n >= HS_START) && (col_n < HS_END)) ? HS_ACT : ~HS_ACT;
            vsync       <= ((row_n >= VS_START) && (row_n < VS_END)) ? VS_ACT : ~VS_ACT;
            new_line    <= (col_n == '0);
            new_frame   <= (col_n == '0) && (row_n == '0);
        end
    end

endmodule
